// File: rtl/node_prec_p.sv
// Primitive-recursion node: acc0 = IN0, acc(i+1) = f(acc(i), IN1, i) for n = IN2 steps.
// Ports: CLK, RST (sync high), ST start level; IN0/IN1/IN2 operands; RD/RES/OVF result.
module node_prec_p #(
  parameter int W    = 16,
  parameter int MODE = 0,
  parameter int SAT  = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  input  logic [W-1:0] IN0,
  input  logic [W-1:0] IN1,
  input  logic [W-1:0] IN2,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         OVF
);

  typedef enum logic {
    IDLE,
    ITER
  } state_e;

  state_e state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] op1_q, op1_d;
  logic [W-1:0] res_q, res_d;
  logic ovf_acc_q, ovf_acc_d;
  logic rd_q, rd_d;
  logic ovf_q, ovf_d;
  logic st_q, st_d;

  logic [W-1:0] opnd;
  logic [W:0]   sum;
  logic         carry;
  logic [W-1:0] stepped;

  always_comb begin
    if (MODE == 1) opnd = op1_q;
    else if (MODE == 2) opnd = cnt_q;
    else opnd = W'(1);
    sum   = {1'b0, acc_q} + {1'b0, opnd};
    carry = sum[W];
    // Saturation pins the accumulator; later steps continue from it.
    if (SAT != 0 && carry) stepped = '1;
    else stepped = sum[W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    op1_d     = op1_q;
    res_d     = res_q;
    ovf_acc_d = ovf_acc_q;
    rd_d      = rd_q;
    ovf_d     = ovf_q;
    st_d      = ST;
    unique case (state_q)
      IDLE: begin
        if (ST && !st_q) begin
          acc_d     = IN0;
          op1_d     = IN1;
          n_d       = IN2;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          rd_d      = 1'b0;
          state_d   = ITER;
        end
      end
      ITER: begin
        // Compare before increment so cnt never wraps at n = 2^W-1.
        if (cnt_q == n_q) begin
          res_d   = acc_q;
          ovf_d   = ovf_acc_q;
          rd_d    = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d     = stepped;
          cnt_d     = cnt_q + W'(1);
          ovf_acc_d = ovf_acc_q | carry;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      op1_q     <= '0;
      res_q     <= '0;
      ovf_acc_q <= 1'b0;
      rd_q      <= 1'b0;
      ovf_q     <= 1'b0;
      st_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      op1_q     <= op1_d;
      res_q     <= res_d;
      ovf_acc_q <= ovf_acc_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
      st_q      <= st_d;
    end
  end

  assign RD  = rd_q;
  assign RES = res_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_node_prec_p.sv
// Bench for node_prec_p: four W=16 instances (MODE/SAT variants) driven in lockstep.
// Results are checked against an arithmetic reference model of the recursion.
module tb_node_prec_p;

  logic        clk;
  logic        rst;
  logic        st;
  logic [15:0] in0, in1, in2;
  logic [3:0]  rd;
  logic [15:0] res [4];
  logic [3:0]  ovf;

  logic [15:0] exp_res [4];
  logic        exp_ovf [4];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance g: 0 -> MODE0, 1 -> MODE1 wrap, 2 -> MODE1 sat, 3 -> MODE2 wrap.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    node_prec_p #(
      .W   (16),
      .MODE((g == 3) ? 2 : ((g >= 1) ? 1 : 0)),
      .SAT ((g == 2) ? 1 : 0)
    ) u_dut (
      .CLK(clk),
      .RST(rst),
      .ST (st),
      .IN0(in0),
      .IN1(in1),
      .IN2(in2),
      .RD (rd[g]),
      .RES(res[g]),
      .OVF(ovf[g])
    );
  end

  function automatic int mode_of(int g);
    return (g == 3) ? 2 : ((g >= 1) ? 1 : 0);
  endfunction

  task automatic model(input int g, input int a0, input int b, input int n);
    longint acc;
    longint add;
    bit     of;
    acc = a0;
    of  = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (mode_of(g))
        0:       add = 1;
        1:       add = b;
        default: add = i;
      endcase
      acc = acc + add;
      if (acc > 65535) begin
        of  = 1'b1;
        acc = (g == 2) ? 65535 : acc - 65536;
      end
    end
    exp_res[g] = 16'(acc);
    exp_ovf[g] = of;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_rd"}, {28'd0, rd}, 32'hF);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_res%0d", tag, g), {16'd0, res[g]}, {16'd0, exp_res[g]});
      chk($sformatf("%s_ovf%0d", tag, g), {31'd0, ovf[g]}, {31'd0, exp_ovf[g]});
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] n);
    @(negedge clk);
    in0 = a;
    in1 = b;
    in2 = n;
    st  = 1'b1;
    for (int g = 0; g < 4; g++) model(g, int'(a), int'(b), int'(n));
  endtask

  // Start edge k is the next posedge; RD must stay low through k+n, rise at k+1+n.
  task automatic finish(input string tag, input int n);
    @(posedge clk); #1;
    chk({tag, "_rd_start"}, {28'd0, rd}, 32'h0);
    @(negedge clk);
    st = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      chk({tag, "_rd_busy"}, {28'd0, rd}, 32'h0);
    end
    @(posedge clk); #1;
    check_results(tag);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] n);
    launch(a, b, n);
    finish(tag, int'(n));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    st  = 1'b0;
    in0 = '0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", {28'd0, rd}, 32'h0);
    chk("reset_ovf", {28'd0, ovf}, 32'h0);
    for (int g = 0; g < 4; g++) chk($sformatf("reset_res%0d", g), {16'd0, res[g]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run("m0_basic", 16'd5, 16'd0, 16'd3);
    run("m1_basic", 16'd2, 16'd7, 16'd4);
    // IN1 changes while RD is high and ST stays low: results must hold.
    @(negedge clk);
    in1 = 16'd9;
    repeat (3) @(posedge clk);
    #1;
    check_results("hold");
    run("m2_basic", 16'd0, 16'd0, 16'd5);
    run("n_zero", 16'h1234, 16'd0, 16'd0);
    run("ovf", 16'hFFF0, 16'h0010, 16'd2);
    run("clean", 16'd1, 16'd1, 16'd1);

    for (int t = 0; t < 30; t++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] n;
      a = 16'($urandom);
      if (t % 3 == 0) a = 16'hFFFF - 16'($urandom_range(0, 40));
      b = 16'($urandom);
      if (t % 2 == 0) b = 16'($urandom_range(0, 20));
      n = 16'($urandom_range(0, 15));
      run("rand", a, b, n);
    end
    run("long", 16'hF000, 16'd200, 16'd300);

    // ST toggling during ITER must be ignored.
    launch(16'd0, 16'd3, 16'd10);
    @(posedge clk); #1;
    chk("tog_rd_start", {28'd0, rd}, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      st = (i < 8) ? 1'(i % 2) : 1'b0;
      @(posedge clk); #1;
      chk("tog_rd_busy", {28'd0, rd}, 32'h0);
    end
    @(posedge clk); #1;
    check_results("tog");

    // Reset mid-run at edge k+4 clears outputs.
    launch(16'd0, 16'd3, 16'd10);
    @(negedge clk);
    st = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_res0", {16'd0, res[0]}, {16'd0, exp_res[0]});
    @(negedge clk);
    rst = 1'b1;
    st  = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rd", {28'd0, rd}, 32'h0);
    chk("mid_rst_ovf", {28'd0, ovf}, 32'h0);
    for (int g = 0; g < 4; g++) chk($sformatf("mid_rst_res%0d", g), {16'd0, res[g]}, 32'h0);

    // ST held high through reset starts a run at the first post-reset edge.
    in0 = 16'd5;
    in1 = 16'd1;
    in2 = 16'd2;
    for (int g = 0; g < 4; g++) model(g, 5, 1, 2);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    finish("st_thru_rst", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
